// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop process the operands
// LSB-first, one bit per clock, behind a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int unsigned    CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_sa;
    logic [WIDTH-1:0]  r_sb;
    logic [WIDTH-1:0]  r_sr;
    logic [WIDTH-1:0]  r_sum;
    logic              r_c;
    logic              r_cout;
    logic [CntW-1:0]   r_cnt;

    logic              w_bit;
    logic              w_carry;
    logic              w_last;
    logic [WIDTH-1:0]  w_sr_next;

    // Full-adder cell on the current LSBs; new bit enters the result at the MSB end
    always_comb begin
        w_bit     = r_sa[0] ^ r_sb[0] ^ r_c;
        w_carry   = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);
        w_last    = (r_cnt == LastCnt);
        w_sr_next = (r_sr >> 1) | (WIDTH'(w_bit) << (WIDTH - 1));
    end

    // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE after the last bit, DONE -> IDLE
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_next = StShift;
            StShift: if (w_last)  w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: capture operands on start, step one bit per SHIFT cycle, publish on the last step
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_sr   <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (r_state == StIdle) begin
            if (i_start) begin
                r_sa  <= i_a;
                r_sb  <= i_b;
                r_c   <= i_cin;
                r_sr  <= '0;
                r_cnt <= '0;
            end
        end else if (r_state == StShift) begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_c   <= w_carry;
            r_sr  <= w_sr_next;
            r_cnt <= r_cnt + CntW'(1);
            // sum/cout only ever change here, so they never show partial results
            if (w_last) begin
                r_sum  <= w_sr_next;
                r_cout <= w_carry;
            end
        end
    end

    assign o_busy = (r_state == StShift);
    assign o_done = (r_state == StDone);
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder with carry-in: adds two operand words LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop. It is the addition counterpart of the team's combinational half-subtractor cell. It sits behind a start/done handshake, so a controller can trade latency for area on the Mimas V2 fabric.

## Interface
- `WIDTH`, default 8: operand and sum width in bits, minimum 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `cin`  in  1  carry-in; sampled with `start`.
- `busy`  out  1  high while bits are being processed (SHIFT state).
- `done`  out  1  one-cycle pulse; `sum`/`cout` are valid from this cycle.
- `sum`  out  WIDTH  result register, (a + b + cin) mod 2^WIDTH.
- `cout`  out  1  carry out of the MSB.

## Operation
- Internal state:
  - shift registers `sa` and `sb`, each WIDTH bits;
  - result shift register `sr`, WIDTH bits;
  - carry flop `c`;
  - bit counter `cnt`, clog2(WIDTH+1) bits.
- FSM states are IDLE, SHIFT and DONE.
- IDLE, with `start`=1:
  - load `sa`←`a`, `sb`←`b`, `c`←`cin`;
  - clear `sr` and `cnt`;
  - go to SHIFT.
- IDLE, with `start`=0: hold all state.
- SHIFT, on each edge:
  - bit = `sa[0]` ^ `sb[0]` ^ `c`;
  - `c` ← majority(`sa[0]`, `sb[0]`, `c`);
  - `sr` ← {bit, `sr[WIDTH-1:1]`};
  - `sa` and `sb` shift right by one;
  - `cnt` increments.
- Leaving SHIFT: the edge with `cnt`==WIDTH-1 performs the last bit step. On the same edge:
  - `sum` ← final `sr` value, including the new bit;
  - `cout` ← new carry;
  - state goes to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE on the next edge.
- `start` is ignored in SHIFT and DONE; there is no queuing.
- `sum` and `cout` hold their values until the next completion. They never show partial results.
- Changes on `a`, `b` or `cin` after the start edge have no effect on the operation in progress.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE;
  - `busy`=0, `done`=0, `sum`=0, `cout`=0;
  - `sa`, `sb`, `sr`, `c` and `cnt` all 0.
- Reset asserted mid-operation aborts the operation. No `done` is produced, and `sum`/`cout` return to 0.
- After reset deasserts, the first `start` is sampled at the next edge while in IDLE.
- Latency, taking `start` sampled at edge 0:
  - `busy` is high after edges 0 through WIDTH-1;
  - the bit steps occur at edges 1..WIDTH;
  - `done` is high in the cycle following edge WIDTH;
  - IDLE is reached after edge WIDTH+1.
- Throughput: with `start` held high, the next operation is accepted at edge WIDTH+2, giving one result every WIDTH+2 cycles.
- `busy` and `done` are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then add, WIDTH=8: `a`=8'h05, `b`=8'h03, `cin`=0, `start` pulsed at edge 0 → `done` high in the cycle after edge 8, with `sum`=8'h08 and `cout`=0.
- Carry wrap: `a`=8'hFF, `b`=8'h01, `cin`=0 → `sum`=8'h00, `cout`=1. Then `a`=8'hFF, `b`=8'hFF, `cin`=1 → `sum`=8'hFF, `cout`=1.
- Ignored start and operand change mid-run: start 8'h10+8'h20. Then pulse `start` with `a`=8'hAA at edge 3, and change `b` at edge 4 → single `done`, `sum`=8'h30. No second operation begins.
- Reset mid-operation: start 8'h7F+8'h01 and assert `rst` at edge 4 → `busy`, `done`, `sum` and `cout` are 0 immediately, and no `done` appears. A subsequent 8'h01+8'h01 gives `sum`=8'h02.
- Back-to-back: hold `start`=1 with `a`=8'h12, `b`=8'h34, `cin`=1 → `done` pulses every 10 cycles, each with `sum`=8'h47 and `cout`=0. `sum` is stable between pulses.
- Random: 1000 random (`a`, `b`, `cin`) at WIDTH=8 and WIDTH=16 → {`cout`,`sum`} equals `a`+`b`+`cin` at every `done`.
